// File: rtl/song_pkg.sv
// Shared definitions for the song sequencer: ROM entry layout, song geometry and FSM states.
package song_pkg;

  localparam int unsigned ENTRY_W  = 16;
  localparam int unsigned ADV_BIT  = 15;
  localparam int unsigned NOTE_MSB = 14;
  localparam int unsigned NOTE_LSB = 9;
  localparam int unsigned DUR_MSB  = 8;
  localparam int unsigned DUR_LSB  = 3;
  localparam int unsigned META_MSB = 2;
  localparam int unsigned META_LSB = 0;

  localparam int unsigned NOTE_W = NOTE_MSB - NOTE_LSB + 1;
  localparam int unsigned DUR_W  = DUR_MSB - DUR_LSB + 1;
  localparam int unsigned META_W = META_MSB - META_LSB + 1;

  localparam logic [NOTE_W-1:0] NOTE_REST = '0;

  localparam int unsigned ENTRIES_PER_SONG = 32;
  localparam int unsigned IDX_W            = $clog2(ENTRIES_PER_SONG);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StWait,
    StDone
  } state_e;

endpackage

// File: rtl/song_sequencer_if.sv
// Song ROM read port plus the note-player load bus driven by the sequencer.
interface song_sequencer_if #(
  parameter int unsigned VOICES    = 3,
  parameter int unsigned SONG_BITS = 2
);

  logic [SONG_BITS+song_pkg::IDX_W-1:0] rom_addr;
  logic [song_pkg::ENTRY_W-1:0]         rom_data;
  logic [VOICES-1:0]                    load;
  logic [song_pkg::NOTE_W-1:0]          note_out;
  logic [song_pkg::DUR_W-1:0]           dur_out;
  logic [song_pkg::META_W-1:0]          meta_out;

  modport master (
    output rom_addr, load, note_out, dur_out, meta_out,
    input  rom_data
  );

  modport slave (
    input  rom_addr, load, note_out, dur_out, meta_out,
    output rom_data
  );

endinterface

// File: rtl/beat_counter.sv
// Loadable down-counter paced by beat pulses; flags the beat that brings it to zero.
module beat_counter #(
  parameter int unsigned Width = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  input  logic             beat_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;
  logic             dec;

  assign dec    = en_i & beat_i & (cnt_q != '0);
  assign zero_o = dec & ~load_i & (cnt_q == Width'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/song_sequencer.sv
// Walks one song in the song ROM, dispatching notes round-robin to the voices and
// timing advancing entries in beats.
module song_sequencer
  import song_pkg::*;
#(
  parameter int unsigned VOICES    = 3,
  parameter int unsigned SONG_BITS = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 play,
  input  logic [SONG_BITS-1:0] song_sel,
  input  logic                 beat,
  output logic                 song_done,
  song_sequencer_if.master     bus
);

  localparam int unsigned VoiceW = (VOICES > 1) ? $clog2(VOICES) : 1;

  state_e                state_q, state_d;
  logic [SONG_BITS-1:0]  song_q, song_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [VoiceW-1:0]     voice_q, voice_d;
  logic [VOICES-1:0]     load_q, load_d;
  logic [NOTE_W-1:0]     note_q, note_d;
  logic [DUR_W-1:0]      dur_q, dur_d;
  logic [META_W-1:0]     meta_q, meta_d;

  logic                  ent_adv;
  logic [NOTE_W-1:0]     ent_note;
  logic [DUR_W-1:0]      ent_dur;
  logic [META_W-1:0]     ent_meta;
  logic                  song_change;
  logic                  last_idx;
  logic [VoiceW-1:0]     voice_next;
  logic                  cnt_load;
  logic                  cnt_en;
  logic                  cnt_zero;

  assign ent_adv  = bus.rom_data[ADV_BIT];
  assign ent_note = bus.rom_data[NOTE_MSB:NOTE_LSB];
  assign ent_dur  = bus.rom_data[DUR_MSB:DUR_LSB];
  assign ent_meta = bus.rom_data[META_MSB:META_LSB];

  assign song_change = (song_sel != song_q);
  assign last_idx    = (idx_q == IDX_W'(ENTRIES_PER_SONG - 1));
  assign voice_next  = (voice_q == VoiceW'(VOICES - 1)) ? '0 : voice_q + VoiceW'(1);
  assign cnt_en      = (state_q == StWait) & play;

  beat_counter #(
    .Width (DUR_W)
  ) u_beat_counter (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (ent_dur),
    .en_i       (cnt_en),
    .beat_i     (beat),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    song_d   = song_q;
    idx_d    = idx_q;
    voice_d  = voice_q;
    load_d   = '0;
    note_d   = note_q;
    dur_d    = dur_q;
    meta_d   = meta_q;
    cnt_load = 1'b0;

    case (state_q)
      StIdle: begin
        if (play) begin
          song_d  = song_sel;
          state_d = StFetch;
        end
      end
      StFetch: state_d = StDecode;
      StDecode: begin
        if (ent_note == NOTE_REST && ent_dur == '0) begin
          state_d = StDone;
        end else begin
          if (ent_note != NOTE_REST) begin
            load_d  = {{(VOICES-1){1'b0}}, 1'b1} << voice_q;
            note_d  = ent_note;
            dur_d   = ent_dur;
            meta_d  = ent_meta;
            voice_d = voice_next;
          end
          if (ent_adv && ent_dur != '0) begin
            cnt_load = 1'b1;
            state_d  = StWait;
          end else if (last_idx) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = StFetch;
          end
        end
      end
      StWait: begin
        if (cnt_zero) begin
          voice_d = '0;
          if (last_idx) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = StFetch;
          end
        end
      end
      StDone: begin
        if (!play) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A new song request wins over everything and drops any pending note.
    if (state_q != StIdle && song_change) begin
      state_d  = StIdle;
      load_d   = '0;
      note_d   = note_q;
      dur_d    = dur_q;
      meta_d   = meta_q;
      cnt_load = 1'b0;
    end

    if (state_d == StIdle) begin
      idx_d   = '0;
      voice_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      song_q  <= '0;
      idx_q   <= '0;
      voice_q <= '0;
      load_q  <= '0;
      note_q  <= '0;
      dur_q   <= '0;
      meta_q  <= '0;
    end else begin
      state_q <= state_d;
      song_q  <= song_d;
      idx_q   <= idx_d;
      voice_q <= voice_d;
      load_q  <= load_d;
      note_q  <= note_d;
      dur_q   <= dur_d;
      meta_q  <= meta_d;
    end
  end

  assign bus.rom_addr = {song_q, idx_q};
  assign bus.load     = load_q;
  assign bus.note_out = note_q;
  assign bus.dur_out  = dur_q;
  assign bus.meta_out = meta_q;
  assign song_done    = (state_q == StDone);

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer: a cycle table for song 0, then hand sequences for
// chords, rests with pause, index wrap, song change and mid-song reset.
module tb_song_sequencer;

  logic       clk;
  logic       reset;
  logic       play;
  logic [1:0] song_sel;
  logic       beat;
  logic       song_done;

  int checks = 0;
  int errors = 0;

  logic [15:0] rom [0:127];

  song_sequencer_if #(.VOICES(3), .SONG_BITS(2)) bus ();

  song_sequencer #(
    .VOICES    (3),
    .SONG_BITS (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .play      (play),
    .song_sel  (song_sel),
    .beat      (beat),
    .song_done (song_done),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  typedef struct {
    logic       rst;
    logic       play;
    logic [1:0] sel;
    logic       beat;
    logic [2:0] load;
    logic [6:0] addr;
    logic       done;
    logic [5:0] note;
    logic [5:0] dur;
    logic [2:0] meta;
  } vec_t;

  vec_t vecs [11];

  function automatic logic [15:0] ent(input logic adv, input int note, input int dur,
                                      input int meta);
    logic [5:0] n;
    logic [5:0] d;
    logic [2:0] m;
    n = note[5:0];
    d = dur[5:0];
    m = meta[2:0];
    return {adv, n, d, m};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic p, input logic [1:0] s, input logic b);
    reset    = r;
    play     = p;
    song_sel = s;
    beat     = b;
    @(posedge clk);
    #1;
  endtask

  // Load must be one-hot and never asserted in two consecutive cycles.
  logic [2:0] load_prev = '0;
  always @(posedge clk) begin
    #2;
    checks++;
    if ((load_prev != 3'b000 && bus.load != 3'b000) || $countones(bus.load) > 1) begin
      errors++;
      $display("FAIL load_pulse: got %b after %b, required isolated one-hot", bus.load,
               load_prev);
    end
    load_prev = bus.load;
  end

  initial begin
    reset    = 1'b1;
    play     = 1'b0;
    song_sel = 2'd0;
    beat     = 1'b0;

    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    rom[0]  = ent(1, 52, 2, 5);
    rom[32] = ent(0, 52, 48, 1);
    rom[33] = ent(0, 56, 32, 2);
    rom[34] = ent(1, 59, 16, 3);
    rom[35] = ent(1, 61, 3, 4);
    rom[36] = ent(1, 0, 34, 6);
    for (int i = 0; i < 32; i++) rom[64+i] = ent(0, i + 1, 0, i % 8);

    //            rst play sel beat load    addr  done note  dur  meta
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 1'b0, 3'b000, 7'd0, 1'b0, 6'd0,  6'd0, 3'd0};
    vecs[1]  = '{1'b0, 1'b1, 2'd0, 1'b0, 3'b000, 7'd0, 1'b0, 6'd0,  6'd0, 3'd0};
    vecs[2]  = '{1'b0, 1'b1, 2'd0, 1'b0, 3'b000, 7'd0, 1'b0, 6'd0,  6'd0, 3'd0};
    vecs[3]  = '{1'b0, 1'b1, 2'd0, 1'b0, 3'b001, 7'd0, 1'b0, 6'd52, 6'd2, 3'd5};
    vecs[4]  = '{1'b0, 1'b1, 2'd0, 1'b1, 3'b000, 7'd0, 1'b0, 6'd52, 6'd2, 3'd5};
    vecs[5]  = '{1'b0, 1'b1, 2'd0, 1'b0, 3'b000, 7'd0, 1'b0, 6'd52, 6'd2, 3'd5};
    vecs[6]  = '{1'b0, 1'b1, 2'd0, 1'b1, 3'b000, 7'd1, 1'b0, 6'd52, 6'd2, 3'd5};
    vecs[7]  = '{1'b0, 1'b1, 2'd0, 1'b0, 3'b000, 7'd1, 1'b0, 6'd52, 6'd2, 3'd5};
    vecs[8]  = '{1'b0, 1'b1, 2'd0, 1'b0, 3'b000, 7'd1, 1'b1, 6'd52, 6'd2, 3'd5};
    vecs[9]  = '{1'b0, 1'b1, 2'd0, 1'b0, 3'b000, 7'd1, 1'b1, 6'd52, 6'd2, 3'd5};
    vecs[10] = '{1'b0, 1'b0, 2'd0, 1'b0, 3'b000, 7'd0, 1'b0, 6'd52, 6'd2, 3'd5};

    for (int i = 0; i < 11; i++) begin
      cyc(vecs[i].rst, vecs[i].play, vecs[i].sel, vecs[i].beat);
      chk($sformatf("v%0d load", i), bus.load, vecs[i].load);
      chk($sformatf("v%0d rom_addr", i), bus.rom_addr, vecs[i].addr);
      chk($sformatf("v%0d song_done", i), song_done, vecs[i].done);
      chk($sformatf("v%0d note_out", i), bus.note_out, vecs[i].note);
      chk($sformatf("v%0d dur_out", i), bus.dur_out, vecs[i].dur);
      chk($sformatf("v%0d meta_out", i), bus.meta_out, vecs[i].meta);
    end

    // Song 1: chord on voices 0,1,2, then a note on voice 0.
    cyc(0, 1, 1, 0); chk("s1 fetch0 addr", bus.rom_addr, 32);
    cyc(0, 1, 1, 0); chk("s1 decode0 load", bus.load, 0);
    cyc(0, 1, 1, 0); chk("chord0 load", bus.load, 1); chk("chord0 note", bus.note_out, 52);
    chk("chord0 dur", bus.dur_out, 48); chk("chord0 addr", bus.rom_addr, 33);
    cyc(0, 1, 1, 0); chk("chord1 gap", bus.load, 0);
    cyc(0, 1, 1, 0); chk("chord1 load", bus.load, 2); chk("chord1 note", bus.note_out, 56);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 0); chk("chord2 load", bus.load, 4); chk("chord2 note", bus.note_out, 59);
    chk("chord2 meta", bus.meta_out, 3); chk("chord2 addr", bus.rom_addr, 34);
    for (int k = 0; k < 15; k++) begin
      cyc(0, 1, 1, 1); chk("wait16 hold", bus.rom_addr, 34);
      cyc(0, 1, 1, 0);
    end
    cyc(0, 1, 1, 1); chk("wait16 fetch", bus.rom_addr, 35);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 0); chk("post-chord voice0", bus.load, 1);
    chk("post-chord note", bus.note_out, 61);
    cyc(0, 1, 1, 1);
    cyc(0, 1, 1, 1); chk("dur3 hold", bus.rom_addr, 35);
    cyc(0, 1, 1, 1); chk("dur3 fetch", bus.rom_addr, 36);

    // Rest of 34 beats; beats in FETCH/DECODE ignored, paused beats not counted.
    cyc(0, 1, 1, 1);
    cyc(0, 1, 1, 1); chk("rest no load", bus.load, 0); chk("rest note hold", bus.note_out, 61);
    for (int k = 0; k < 20; k++) begin
      cyc(0, 1, 1, 1); chk("rest hold a", bus.rom_addr, 36);
    end
    for (int k = 0; k < 10; k++) begin
      cyc(0, 0, 1, 1); chk("rest paused", bus.rom_addr, 36);
    end
    for (int k = 0; k < 13; k++) begin
      cyc(0, 1, 1, 1); chk("rest hold b", bus.rom_addr, 36);
    end
    cyc(0, 1, 1, 1); chk("rest 34th beat", bus.rom_addr, 37);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 0); chk("s1 done", song_done, 1);

    // Song 2: 32 chord entries, index wraps into DONE.
    cyc(0, 1, 2, 0); chk("done->idle on change", song_done, 0);
    chk("idle addr", bus.rom_addr, 32);
    cyc(0, 1, 2, 0);
    for (int i = 0; i < 32; i++) begin
      chk("s2 fetch addr", bus.rom_addr, 64 + i);
      cyc(0, 1, 2, 0); chk("s2 decode load", bus.load, 0);
      cyc(0, 1, 2, 0); chk("s2 load", bus.load, 32'(1) << (i % 3));
      chk("s2 note", bus.note_out, i + 1);
    end
    chk("s2 wrap done", song_done, 1); chk("s2 last addr", bus.rom_addr, 95);

    // Song change during WAIT and during DECODE.
    cyc(0, 1, 1, 0);
    for (int k = 0; k < 7; k++) cyc(0, 1, 1, 0);
    chk("s1 again chord2", bus.load, 4);
    cyc(0, 1, 1, 1);
    cyc(0, 1, 2, 0); chk("chg wait load", bus.load, 0); chk("chg wait addr", bus.rom_addr, 32);
    chk("chg wait done", song_done, 0);
    cyc(0, 1, 2, 0); chk("chg fetch addr", bus.rom_addr, 64); chk("chg fetch load", bus.load, 0);
    cyc(0, 1, 2, 0);
    cyc(0, 1, 3, 0); chk("chg decode no load", bus.load, 0);
    chk("chg decode addr", bus.rom_addr, 64);
    cyc(0, 1, 3, 0); chk("s3 fetch addr", bus.rom_addr, 96);
    cyc(0, 1, 3, 0);
    cyc(0, 1, 3, 0); chk("s3 end marker", song_done, 1);

    // Reset during a chord DECODE.
    cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 0); chk("pre-reset load", bus.load, 1);
    cyc(0, 1, 1, 0);
    cyc(1, 1, 1, 0);
    chk("rst load", bus.load, 0); chk("rst note", bus.note_out, 0);
    chk("rst dur", bus.dur_out, 0); chk("rst meta", bus.meta_out, 0);
    chk("rst addr", bus.rom_addr, 0); chk("rst done", song_done, 0);
    cyc(0, 0, 1, 0); chk("rst no pending load", bus.load, 0);
    cyc(0, 1, 1, 0); chk("rst restart addr", bus.rom_addr, 32);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 0); chk("rst restart voice0", bus.load, 1);
    chk("rst restart note", bus.note_out, 52);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
